// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, optional even parity, stop bit.
// Delivers each word with a one-cycle dvalid pulse; a low stop bit raises ferr and waits out the break.
module serial_frame_rx #(
  parameter int DATA_W    = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  output logic [DATA_W-1:0] dout,
  output logic              dvalid,
  output logic              perr,
  output logic              ferr,
  output logic              busy
);

  localparam int                 CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP   = 3'd3,
    ST_BREAK  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                pflag_q, pflag_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                dvalid_q, dvalid_d;
  logic                perr_q, perr_d;
  logic                ferr_q, ferr_d;
  logic                busy_q, busy_d;

  // Even parity: data bits plus parity bit must XOR to zero, so a nonzero XOR is an error.
  function automatic logic even_parity_err(input logic [DATA_W-1:0] data, input logic pbit);
    return (^data) ^ pbit;
  endfunction

  // Next-state and next-output logic for the frame FSM.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    pflag_d  = pflag_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    perr_d   = 1'b0;
    ferr_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!din) begin
          state_d = ST_DATA;
          cnt_d   = '0;
          pflag_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        // Right shift so the first (LSB) bit ends up at bit 0 after DATA_W shifts.
        shift_d             = shift_q >> 1;
        shift_d[DATA_W-1]   = din;
        cnt_d               = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = PARITY_EN ? ST_PARITY : ST_STOP;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        pflag_d = even_parity_err(shift_q, din);
        state_d = ST_STOP;
      end
      ST_STOP: begin
        if (din) begin
          dout_d   = shift_q;
          dvalid_d = 1'b1;
          perr_d   = pflag_q;
          state_d  = ST_IDLE;
        end else begin
          ferr_d   = 1'b1;
          state_d  = ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (din) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BREAK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      pflag_q  <= 1'b0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      pflag_q  <= pflag_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      busy_q   <= busy_d;
    end
  end

  assign dout   = dout_q;
  assign dvalid = dvalid_q;
  assign perr   = perr_q;
  assign ferr   = ferr_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: one instance with parity, one without, directed frames then random frames.
// Expected results come from frame-level arithmetic (data, parity of the word, stop bit value).
module tb_serial_frame_rx;

  logic       clk;
  logic       rst;
  logic       din_p, din_np;
  logic [7:0] dout_p, dout_np;
  logic       dvalid_p, dvalid_np, perr_p, perr_np, ferr_p, ferr_np, busy_p, busy_np;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic sel = 1'b0;
  logic [7:0] exp_dout [2];

  logic [7:0] o_dout;
  logic       o_dvalid, o_perr, o_ferr, o_busy;
  assign o_dout   = sel ? dout_np   : dout_p;
  assign o_dvalid = sel ? dvalid_np : dvalid_p;
  assign o_perr   = sel ? perr_np   : perr_p;
  assign o_ferr   = sel ? ferr_np   : ferr_p;
  assign o_busy   = sel ? busy_np   : busy_p;

  serial_frame_rx #(.DATA_W(8), .PARITY_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .din(din_p), .dout(dout_p),
    .dvalid(dvalid_p), .perr(perr_p), .ferr(ferr_p), .busy(busy_p)
  );

  serial_frame_rx #(.DATA_W(8), .PARITY_EN(1'b0)) dut_np (
    .clk(clk), .rst(rst), .din(din_np), .dout(dout_np),
    .dvalid(dvalid_np), .perr(perr_np), .ferr(ferr_np), .busy(busy_np)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one bit on the selected line, then look at outputs just after the edge that sampled it.
  task automatic step(input logic b);
    if (sel) begin
      din_np = b;
      din_p  = 1'b1;
    end else begin
      din_p  = b;
      din_np = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic mid_frame(input string tag);
    chk({tag, "_busy"}, 32'(o_busy), 32'd1);
    chk({tag, "_pulses"}, 32'({o_dvalid, o_perr, o_ferr}), 32'd0);
  endtask

  task automatic idle_step();
    step(1'b1);
    chk("idle_busy", 32'(o_busy), 32'd0);
    chk("idle_pulses", 32'({o_dvalid, o_perr, o_ferr}), 32'd0);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic pbit, input logic stop, input int brk);
    logic use_par;
    use_par = ~sel;
    step(1'b0);
    mid_frame("start");
    for (int i = 0; i < 8; i++) begin
      step(data[i]);
      mid_frame("data");
    end
    if (use_par) begin
      step(pbit);
      mid_frame("par");
    end
    step(stop);
    if (stop) begin
      exp_dout[sel] = data;
      chk("stop_dvalid", 32'(o_dvalid), 32'd1);
      chk("stop_dout", 32'(o_dout), 32'(data));
      chk("stop_perr", 32'(o_perr), use_par ? 32'((^data) ^ pbit) : 32'd0);
      chk("stop_ferr", 32'(o_ferr), 32'd0);
      chk("stop_busy", 32'(o_busy), 32'd0);
    end else begin
      chk("ferr_pulse", 32'(o_ferr), 32'd1);
      chk("ferr_nodvalid", 32'({o_dvalid, o_perr}), 32'd0);
      chk("ferr_dout", 32'(o_dout), 32'(exp_dout[sel]));
      chk("ferr_busy", 32'(o_busy), 32'd1);
      for (int k = 0; k < brk; k++) begin
        step(1'b0);
        mid_frame("break");
      end
      step(1'b1);
      chk("brk_exit_busy", 32'(o_busy), 32'd0);
      chk("brk_exit_pulses", 32'({o_dvalid, o_perr, o_ferr}), 32'd0);
      chk("brk_exit_dout", 32'(o_dout), 32'(exp_dout[sel]));
    end
  endtask

  initial begin
    int c1, cs, nfr;
    logic [7:0] d;
    logic pb, sb;
    rst    = 1'b1;
    din_p  = 1'b1;
    din_np = 1'b1;
    exp_dout[0] = 8'h00;
    exp_dout[1] = 8'h00;

    // Reset and idle
    step(1'b1);
    step(1'b1);
    chk("rst_outputs_p", 32'({dout_p, dvalid_p, perr_p, ferr_p, busy_p}), 32'd0);
    chk("rst_outputs_np", 32'({dout_np, dvalid_np, perr_np, ferr_np, busy_np}), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1);
      chk("idle_all", 32'({dout_p, dvalid_p, perr_p, ferr_p, busy_p}), 32'd0);
    end

    // Good frame, parity error, framing error with break, recovery
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    idle_step();
    send_frame(8'hA5, 1'b1, 1'b1, 0);
    idle_step();
    send_frame(8'h3C, 1'b0, 1'b0, 5);
    send_frame(8'h5A, 1'b0, 1'b1, 0);
    idle_step();

    // Back-to-back frames, no idle bits
    send_frame(8'h3C, 1'b0, 1'b1, 0);
    c1 = cyc;
    send_frame(8'hFF, 1'b0, 1'b1, 0);
    chk("b2b_spacing", 32'(cyc - c1), 32'd11);
    idle_step();

    // Reset at edge S+4 aborts the frame
    step(1'b0);
    step(1'b1);
    step(1'b0);
    step(1'b1);
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    exp_dout[0] = 8'h00;
    exp_dout[1] = 8'h00;
    chk("midrst_outputs", 32'({dout_p, dvalid_p, perr_p, ferr_p, busy_p}), 32'd0);
    for (int i = 0; i < 12; i++) begin
      idle_step();
    end

    // No-parity instance: 10-bit frame for 0x81
    sel = 1'b1;
    idle_step();
    cs = cyc + 1;
    send_frame(8'h81, 1'b0, 1'b1, 0);
    chk("np_latency", 32'(cyc - cs), 32'd9);
    idle_step();

    // Random frames on both instances
    for (nfr = 0; nfr < 60; nfr++) begin
      sel = 1'($urandom_range(0, 1));
      d   = 8'($urandom);
      pb  = (^d) ^ ($urandom_range(0, 3) == 0);
      sb  = ($urandom_range(0, 4) != 0);
      send_frame(d, pb, sb, int'($urandom_range(0, 3)));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        idle_step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
